adder_seq_ctrl: RTL

//  Multi-cycle controller that computes WIDTH-bit add/subtract on one shared 3-bit ripple adder slice.

---
 rtl/adder_seq_ctrl_if.sv | 21 ++
 rtl/adder_seq_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: operand request and result handshake bundle for adder_seq_ctrl
interface adder_seq_ctrl_if #(parameter int WIDTH = 12);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: WIDTH-bit add/sub sequenced LSB-first over an external 3-bit adder slice
module adder_seq_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_seq_ctrl_if.slave      bus,
  output logic [2:0]           sl_a_o,
  output logic [2:0]           sl_b_o,
  output logic                 sl_cin_o,
  input  logic [2:0]           sl_sum_i,
  input  logic                 sl_cout_i
);
  localparam int NSLICE = WIDTH / 3;
  localparam int IDXW   = NSLICE > 1 ? $clog2(NSLICE) : 1;
  if (WIDTH % 3 != 0) begin : g_width_check
    $error("adder_seq_ctrl: WIDTH must be a multiple of 3");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                      state_q, state_d;
  logic [NSLICE-1:0][2:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic                        carry_q, carry_d;
  logic [WIDTH-1:0]            res_q, res_d;
  logic                        cy_q, cy_d, ovf_q, ovf_d;
  logic                        run;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
    end
  end
  assign run = state_q == RUN;
  // the slice is combinational, so its result is captured on the same edge it is presented
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    res_d    = res_q;
    cy_d     = cy_q;
    ovf_d    = ovf_q;
    sl_a_o   = run ? a_q[idx_q] : 3'd0;
    sl_b_o   = run ? b_q[idx_q] : 3'd0;
    sl_cin_o = run & carry_q;
    if (state_q == IDLE && bus.in_valid) begin
      state_d = RUN;
      a_d     = bus.in_a;
      b_d     = bus.in_b ^ {WIDTH{bus.in_sub}};
      carry_d = bus.in_sub;
      idx_d   = '0;
      sum_d   = '0;
    end else if (run) begin
      sum_d[idx_q] = sl_sum_i;
      carry_d      = sl_cout_i;
      idx_d        = idx_q + 1'b1;
      if (idx_q == IDXW'(NSLICE - 1)) begin
        state_d = DONE;
        res_d   = sum_d;
        cy_d    = sl_cout_i;
        ovf_d   = (a_q[NSLICE-1][2] == b_q[NSLICE-1][2]) && (sum_d[NSLICE-1][2] != a_q[NSLICE-1][2]);
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_sum   = res_q;
  assign bus.out_carry = cy_q;
  assign bus.out_ovf   = ovf_q;
endmodule
